corelet_seq: RTL and testbench

CORELET_SEQ -- requirements
Module: corelet_seq

---
 rtl/corelet_seq_pkg.sv | 25 ++
 rtl/corelet_seq_if.sv | 21 ++
 rtl/corelet_seq_ofifo.sv | 49 ++++
 rtl/mac_array.sv | 60 ++++++
 rtl/corelet_seq.sv | 171 +++++++++++++++++
 tb/tb_corelet_seq.sv | 211 +++++++++++++++++++++
 6 files changed

// File: rtl/corelet_seq_pkg.sv
// rtl/corelet_seq_pkg.sv - shared types and constants for the corelet sequencer
package corelet_seq_pkg;

  localparam int ROW_DEF     = 8;
  localparam int COL_DEF     = 8;
  localparam int BW_DEF      = 4;
  localparam int PSUM_BW_DEF = 16;
  localparam int DEPTH_DEF   = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_LOAD,
    S_EXEC,
    S_DRAIN,
    S_DONE
  } state_t;

  typedef logic [1:0] inst_t;

  localparam inst_t INST_IDLE = 2'b00;
  localparam inst_t INST_LOAD = 2'b01;
  localparam inst_t INST_EXEC = 2'b10;

endpackage

// File: rtl/corelet_seq_if.sv
// rtl/corelet_seq_if.sv - input word stream and result stream of the corelet
interface corelet_seq_if
  import corelet_seq_pkg::*;
#(
  parameter int ROW     = ROW_DEF,
  parameter int COL     = COL_DEF,
  parameter int BW      = BW_DEF,
  parameter int PSUM_BW = PSUM_BW_DEF
);
  logic                   in_valid;
  logic                   in_ready;
  logic [ROW*BW-1:0]      in_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [COL*PSUM_BW-1:0] out_data;

  modport master (output in_valid, in_data, out_ready,
                  input  in_ready, out_valid, out_data);
  modport slave  (input  in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_data);
endinterface

// File: rtl/corelet_seq_ofifo.sv
// rtl/corelet_seq_ofifo.sv - first-word fall-through result FIFO with free-slot count
module corelet_ofifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       valid,
  output logic [$clog2(DEPTH+1)-1:0] free
);
  localparam int AW = $clog2(DEPTH);
  localparam int NW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [NW-1:0]    cnt_q;
  logic             do_push, do_pop;

  assign valid    = (cnt_q != '0);
  assign free     = NW'(DEPTH) - cnt_q;
  assign do_pop   = pop && valid;
  assign do_push  = push && ((cnt_q != NW'(DEPTH)) || do_pop);
  // Empty reads as zero so the output bus is quiet after reset.
  assign pop_data = valid ? mem[rd_q] : '0;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q] <= push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= (wr_q == AW'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
      if (do_pop)  rd_q <= (rd_q == AW'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

// File: rtl/mac_array.sv
// rtl/mac_array.sv - weight-stationary MAC array: LOAD latches one weight column
// per cycle, EXEC produces one registered psum vector per activation word.
module mac_array
  import corelet_seq_pkg::*;
#(
  parameter int ROW     = ROW_DEF,
  parameter int COL     = COL_DEF,
  parameter int BW      = BW_DEF,
  parameter int PSUM_BW = PSUM_BW_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [ROW*BW-1:0]      in_w,
  input  inst_t                  inst_w,
  output logic [COL*PSUM_BW-1:0] out_s,
  output logic                   valid
);
  localparam int LW = $clog2(COL + ROW + 1);
  localparam int WA = $clog2(COL);

  logic [ROW*BW-1:0]      w_q [COL];
  logic [LW-1:0]          ld_cnt_q;
  logic [COL*PSUM_BW-1:0] sum_d;
  logic signed [PSUM_BW-1:0] a_ext, w_ext, acc;

  // Activations are unsigned, weights signed; both widened before multiply.
  always_comb begin
    sum_d = '0;
    a_ext = '0;
    w_ext = '0;
    acc   = '0;
    for (int c = 0; c < COL; c++) begin
      acc = '0;
      for (int r = 0; r < ROW; r++) begin
        a_ext = PSUM_BW'($signed({1'b0, in_w[r*BW +: BW]}));
        w_ext = PSUM_BW'($signed(w_q[c][r*BW +: BW]));
        acc   = acc + a_ext * w_ext;
      end
      sum_d[c*PSUM_BW +: PSUM_BW] = acc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ld_cnt_q <= '0;
      valid    <= 1'b0;
      out_s    <= '0;
      for (int c = 0; c < COL; c++) w_q[c] <= '0;
    end else begin
      valid <= (inst_w == INST_EXEC);
      if (inst_w == INST_EXEC) out_s <= sum_d;
      if (inst_w == INST_LOAD) begin
        if (ld_cnt_q < LW'(COL)) w_q[ld_cnt_q[WA-1:0]] <= in_w;
        ld_cnt_q <= ld_cnt_q + 1'b1;
      end else begin
        ld_cnt_q <= '0;
      end
    end
  end
endmodule

// File: rtl/corelet_seq.sv
// rtl/corelet_seq.sv - tile sequencer: buffers weights/activations, drives the MAC
// array, accumulates per-pixel sums and queues results.
module corelet_seq
  import corelet_seq_pkg::*;
#(
  parameter int ROW     = ROW_DEF,
  parameter int COL     = COL_DEF,
  parameter int BW      = BW_DEF,
  parameter int PSUM_BW = PSUM_BW_DEF,
  parameter int DEPTH   = DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [$clog2(DEPTH+1)-1:0] cfg_npix,
  input  logic                       cfg_acc,
  input  logic                       cfg_relu,
  corelet_seq_if.slave               bus,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);
  localparam int NW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam int WA = $clog2(COL);
  localparam int CW = $clog2(COL + ROW + DEPTH + 1);
  localparam int DW = ROW * BW;
  localparam int OW = COL * PSUM_BW;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [NW-1:0] cap_q, cap_d, npix_q, npix_d;
  logic          acc_q, acc_d, relu_q, relu_d, err_q, err_d;

  logic [DW-1:0] wbuf_q  [COL];
  logic [DW-1:0] abuf_q  [DEPTH];
  logic [OW-1:0] store_q [DEPTH];

  logic          sub_rst, in_fire, npix_ok, mac_valid;
  inst_t         inst_w;
  logic [DW-1:0] mac_in;
  logic [OW-1:0] mac_out, res, res_out;
  logic [NW-1:0] fifo_free;
  logic [AW-1:0] fill_idx;
  logic signed [PSUM_BW-1:0] s;

  assign sub_rst      = ~reset;
  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);
  assign err          = err_q;
  assign bus.in_ready = (state_q == S_FILL);
  assign in_fire      = bus.in_valid && (state_q == S_FILL);
  assign npix_ok      = (cfg_npix != '0) && (cfg_npix <= NW'(DEPTH));
  assign fill_idx     = AW'(cnt_q - CW'(COL));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap_d   = cap_q;
    npix_d  = npix_q;
    acc_d   = acc_q;
    relu_d  = relu_q;
    err_d   = err_q;
    inst_w  = INST_IDLE;
    mac_in  = '0;
    if (start && state_q != S_IDLE) err_d = 1'b1;
    if (mac_valid) cap_d = cap_q + 1'b1;
    case (state_q)
      S_IDLE: if (start) begin
        if (npix_ok) begin
          state_d = S_FILL;
          cnt_d   = '0;
          cap_d   = '0;
          npix_d  = cfg_npix;
          acc_d   = cfg_acc;
          relu_d  = cfg_relu;
        end else begin
          err_d = 1'b1;
        end
      end
      S_FILL: if (in_fire) begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(COL) + CW'(npix_q) - CW'(1)) begin
          state_d = S_LOAD;
          cnt_d   = '0;
        end
      end
      // Weight load runs COL+ROW cycles, then holds until the FIFO can absorb the tile.
      S_LOAD: begin
        if (cnt_q < CW'(COL + ROW)) begin
          inst_w = INST_LOAD;
          if (cnt_q < CW'(COL)) mac_in = wbuf_q[cnt_q[WA-1:0]];
          cnt_d = cnt_q + 1'b1;
        end else if (fifo_free >= npix_q) begin
          state_d = S_EXEC;
          cnt_d   = '0;
        end
      end
      S_EXEC: begin
        inst_w = INST_EXEC;
        mac_in = abuf_q[cnt_q[AW-1:0]];
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CW'(npix_q) - CW'(1)) state_d = S_DRAIN;
      end
      S_DRAIN: if (mac_valid && cap_q == npix_q - NW'(1)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Store keeps the pre-ReLU sum; only the queued copy is clamped.
  always_comb begin
    res     = '0;
    res_out = '0;
    s       = '0;
    for (int c = 0; c < COL; c++) begin
      s = $signed(mac_out[c*PSUM_BW +: PSUM_BW]);
      if (acc_q) s = s + $signed(store_q[cap_q[AW-1:0]][c*PSUM_BW +: PSUM_BW]);
      res[c*PSUM_BW +: PSUM_BW]     = s;
      res_out[c*PSUM_BW +: PSUM_BW] = (relu_q && s[PSUM_BW-1]) ? '0 : s;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      cap_q   <= '0;
      npix_q  <= '0;
      acc_q   <= 1'b0;
      relu_q  <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < COL; i++)   wbuf_q[i]  <= '0;
      for (int i = 0; i < DEPTH; i++) abuf_q[i]  <= '0;
      for (int i = 0; i < DEPTH; i++) store_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cap_q   <= cap_d;
      npix_q  <= npix_d;
      acc_q   <= acc_d;
      relu_q  <= relu_d;
      err_q   <= err_d;
      if (in_fire) begin
        if (cnt_q < CW'(COL)) wbuf_q[cnt_q[WA-1:0]] <= bus.in_data;
        else                  abuf_q[fill_idx]      <= bus.in_data;
      end
      if (mac_valid) store_q[cap_q[AW-1:0]] <= res;
    end
  end

  mac_array #(.ROW(ROW), .COL(COL), .BW(BW), .PSUM_BW(PSUM_BW)) u_mac (
    .clk    (clk),
    .reset  (sub_rst),
    .in_w   (mac_in),
    .inst_w (inst_w),
    .out_s  (mac_out),
    .valid  (mac_valid)
  );

  corelet_ofifo #(.WIDTH(OW), .DEPTH(DEPTH)) u_ofifo (
    .clk       (clk),
    .reset     (sub_rst),
    .push      (mac_valid),
    .push_data (res_out),
    .pop       (bus.out_valid && bus.out_ready),
    .pop_data  (bus.out_data),
    .valid     (bus.out_valid),
    .free      (fifo_free)
  );
endmodule

// File: tb/tb_corelet_seq.sv
// tb/tb_corelet_seq.sv - directed self-checking bench for corelet_seq
module tb_corelet_seq;
  localparam int ROW = 8, COL = 8, BW = 4, PSUM_BW = 16, DEPTH = 16;
  localparam int OW = COL * PSUM_BW;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [4:0] cfg_npix = '0;
  logic       cfg_acc = 1'b0;
  logic       cfg_relu = 1'b0;
  logic       busy, done, err;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [OW-1:0] outq [$];

  always #5 clk = ~clk;

  corelet_seq_if #(.ROW(ROW), .COL(COL), .BW(BW), .PSUM_BW(PSUM_BW)) ifc ();

  corelet_seq #(.ROW(ROW), .COL(COL), .BW(BW), .PSUM_BW(PSUM_BW), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (rst_n),
    .start    (start),
    .cfg_npix (cfg_npix),
    .cfg_acc  (cfg_acc),
    .cfg_relu (cfg_relu),
    .bus      (ifc),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always @(negedge clk) begin
    #1;
    if (ifc.out_valid && ifc.out_ready) outq.push_back(ifc.out_data);
    if (done) done_cnt++;
  end

  function automatic logic [OW-1:0] rep(input logic [15:0] v);
    return {COL{v}};
  endfunction

  task automatic chk(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input int npix, input bit acc, input bit relu);
    start    = 1'b1;
    cfg_npix = 5'(npix);
    cfg_acc  = acc;
    cfg_relu = relu;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic [ROW*BW-1:0] d);
    int t;
    t = 0;
    ifc.in_valid = 1'b1;
    ifc.in_data  = d;
    while (!ifc.in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("send_ready", 0, 1);
    @(negedge clk);
    ifc.in_valid = 1'b0;
  endtask

  task automatic run_tile(input logic [3:0] w, input int a0, input int ainc,
                          input int npix, input bit acc, input bit relu);
    logic [3:0] a;
    pulse_start(npix, acc, relu);
    for (int k = 0; k < COL; k++) send({ROW{w}});
    for (int p = 0; p < npix; p++) begin
      a = 4'(a0 + p * ainc);
      send({ROW{a}});
    end
  endtask

  task automatic wait_done(input string tag, input int budget);
    int d0, t;
    d0 = done_cnt;
    t  = 0;
    while (done_cnt == d0 && t < budget) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    chk({tag, "_done_once"}, done_cnt - d0, 1);
    chk({tag, "_busy_low"}, busy, 0);
  endtask

  task automatic chk_outs(input string tag, input int off, input int n, input int v0, input int inc);
    logic [OW-1:0] obs;
    for (int i = 0; i < n; i++) begin
      obs = (off + i < outq.size()) ? outq[off + i] : 'x;
      chk($sformatf("%s_pix%0d", tag, i), obs, rep(16'(v0 + i * inc)));
    end
  endtask

  initial begin
    int dc;
    ifc.in_valid  = 1'b0;
    ifc.in_data   = '0;
    ifc.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_in_ready", ifc.in_ready, 0);
    chk("rst_out_valid", ifc.out_valid, 0);
    chk("rst_out_data", ifc.out_data, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // +1 weights, activation 2, accumulate sequence 16 -> 32 -> 16
    outq.delete(); run_tile(4'h1, 2, 0, 4, 0, 0); wait_done("t1", 200);
    chk("t1_n", outq.size(), 4); chk_outs("t1", 0, 4, 16, 0);
    outq.delete(); run_tile(4'h1, 2, 0, 4, 1, 0); wait_done("t2", 200);
    chk("t2_n", outq.size(), 4); chk_outs("t2", 0, 4, 32, 0);
    outq.delete(); run_tile(4'h1, 2, 0, 4, 0, 0); wait_done("t3", 200);
    chk("t3_n", outq.size(), 4); chk_outs("t3", 0, 4, 16, 0);

    // -1 weights, activation 3: -24, clamped 0, then accumulated -48
    outq.delete(); run_tile(4'hF, 3, 0, 4, 0, 0); wait_done("t4", 200);
    chk("t4_n", outq.size(), 4); chk_outs("t4", 0, 4, 16'hFFE8, 0);
    outq.delete(); run_tile(4'hF, 3, 0, 4, 0, 1); wait_done("t5", 200);
    chk("t5_n", outq.size(), 4); chk_outs("t5", 0, 4, 0, 0);
    outq.delete(); run_tile(4'hF, 3, 0, 4, 1, 0); wait_done("t6", 200);
    chk("t6_n", outq.size(), 4); chk_outs("t6", 0, 4, 16'hFFD0, 0);
    chk("err_clean", err, 0);

    // Full FIFO: second tile must stall before EXEC, then all 32 results in order
    outq.delete();
    ifc.out_ready = 1'b0;
    run_tile(4'h1, 15, 15, 16, 0, 0); wait_done("f1", 300);
    chk("f1_valid", ifc.out_valid, 1);
    chk("f1_head", ifc.out_data, rep(16'd120));
    dc = done_cnt;
    run_tile(4'h1, 1, 0, 16, 1, 0);
    repeat (40) @(negedge clk);
    chk("f2_stall_busy", busy, 1);
    chk("f2_stall_in_ready", ifc.in_ready, 0);
    chk("f2_stall_no_done", done_cnt - dc, 0);
    chk("f2_stall_no_pop", outq.size(), 0);
    ifc.out_ready = 1'b1;
    wait_done("f2", 300);
    chk("f2_n", outq.size(), 32);
    chk_outs("f2a", 0, 16, 120, -8);
    chk_outs("f2b", 16, 16, 128, -8);

    // Start while executing flags err but the tile still completes
    outq.delete();
    run_tile(4'h1, 2, 0, 4, 0, 0);
    repeat (17) @(negedge clk);
    pulse_start(4, 0, 0);
    chk("exec_start_err", err, 1);
    wait_done("t7", 200);
    chk("t7_n", outq.size(), 4); chk_outs("t7", 0, 4, 16, 0);

    // Illegal pixel counts
    rst_n = 1'b0; #1;
    chk("rst2_err_clear", err, 0);
    @(negedge clk); rst_n = 1'b1; @(negedge clk);
    pulse_start(0, 0, 0);
    chk("npix0_err", err, 1);
    chk("npix0_busy", busy, 0);
    @(negedge clk);
    chk("npix0_idle", busy, 0);
    chk("npix0_in_ready", ifc.in_ready, 0);
    rst_n = 1'b0; @(negedge clk); rst_n = 1'b1; @(negedge clk);
    pulse_start(17, 0, 0);
    chk("npix17_err", err, 1);
    chk("npix17_busy", busy, 0);
    rst_n = 1'b0; @(negedge clk); rst_n = 1'b1; @(negedge clk);

    // Asynchronous reset mid-EXEC with results still queued
    ifc.out_ready = 1'b0;
    run_tile(4'h1, 2, 0, 4, 0, 0); wait_done("t8", 200);
    chk("t8_queued", ifc.out_valid, 1);
    run_tile(4'h1, 2, 0, 4, 0, 0);
    repeat (18) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_err", err, 0);
    chk("arst_in_ready", ifc.in_ready, 0);
    chk("arst_out_valid", ifc.out_valid, 0);
    chk("arst_out_data", ifc.out_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ifc.out_ready = 1'b1;
    outq.delete();
    @(negedge clk);
    run_tile(4'h1, 2, 0, 4, 1, 0); wait_done("t9", 200);
    chk("t9_n", outq.size(), 4); chk_outs("t9", 0, 4, 16, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
